ram16s_arbiter: RTL and testbench

RAM16S_ARBITER -- requirements
Module: ram16s_arbiter

---
 rtl/ram16s_arbiter.sv | 156 +++++++++++++++
 tb/tb_ram16s_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram16s_arbiter.sv
// Round-robin arbiter giving two requesters access to one shared 16x8 single-port RAM.
// Define RAM16S_ARB_CLEAR_EN to fill the RAM with CLEAR_VAL after every reset release.
module ram16s_arbiter #(
    parameter logic [7:0] CLEAR_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [3:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [3:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_rvalid,
    output logic       b_rvalid,
    output logic [7:0] a_rdata,
    output logic [7:0] b_rdata,
    output logic [3:0] ram_ad,
    output logic [7:0] ram_di,
    output logic       ram_wre,
    input  logic [7:0] ram_dout,
    output logic       busy
);

`ifdef RAM16S_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state, state_n;
    logic       last_a, last_a_n;   // 1 when A was granted last; B then wins a tie
    logic       owner_b, owner_b_n; // requester of the access in flight
    logic       win_b;
    logic       a_gnt_n, b_gnt_n, a_rvalid_n, b_rvalid_n, ram_wre_n;
    logic [7:0] a_rdata_n, b_rdata_n, ram_di_n;
    logic [3:0] ram_ad_n;

`ifdef RAM16S_ARB_CLEAR_EN
    logic [3:0] cnt, cnt_n;
    logic       busy_q, busy_n;
    assign busy = busy_q;
`else
    logic [7:0] unused_clear_val;
    assign unused_clear_val = CLEAR_VAL;
    assign busy = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        last_a_n   = last_a;
        owner_b_n  = owner_b;
        win_b      = 1'b0;
        a_gnt_n    = 1'b0;
        b_gnt_n    = 1'b0;
        a_rvalid_n = 1'b0;
        b_rvalid_n = 1'b0;
        a_rdata_n  = a_rdata;
        b_rdata_n  = b_rdata;
        ram_ad_n   = ram_ad;
        ram_di_n   = ram_di;
        ram_wre_n  = 1'b0;
`ifdef RAM16S_ARB_CLEAR_EN
        cnt_n      = cnt;
        busy_n     = 1'b0;
`endif
        case (state)
`ifdef RAM16S_ARB_CLEAR_EN
            CLEAR: begin
                ram_ad_n  = cnt;
                ram_di_n  = CLEAR_VAL;
                ram_wre_n = 1'b1;
                busy_n    = 1'b1;
                cnt_n     = cnt + 4'd1;
                if (cnt == 4'hf) state_n = IDLE;
            end
`endif
            IDLE: begin
                if (a_req || b_req) begin
                    win_b     = b_req && (!a_req || last_a);
                    owner_b_n = win_b;
                    last_a_n  = !win_b;
                    ram_ad_n  = win_b ? b_addr  : a_addr;
                    ram_di_n  = win_b ? b_wdata : a_wdata;
                    ram_wre_n = win_b ? b_we    : a_we;
                    a_gnt_n   = !win_b;
                    b_gnt_n   = win_b;
                    state_n   = ACCESS;
                end
            end
            ACCESS: begin
                // RAM read data is asynchronous, so it is valid for the whole ACCESS cycle
                if (!ram_wre) begin
                    if (owner_b) begin
                        b_rdata_n  = ram_dout;
                        b_rvalid_n = 1'b1;
                    end else begin
                        a_rdata_n  = ram_dout;
                        a_rvalid_n = 1'b1;
                    end
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            last_a   <= 1'b0;
            owner_b  <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= 8'h00;
            b_rdata  <= 8'h00;
            ram_ad   <= 4'h0;
            ram_di   <= 8'h00;
            ram_wre  <= 1'b0;
        end else begin
            state    <= state_n;
            last_a   <= last_a_n;
            owner_b  <= owner_b_n;
            a_gnt    <= a_gnt_n;
            b_gnt    <= b_gnt_n;
            a_rvalid <= a_rvalid_n;
            b_rvalid <= b_rvalid_n;
            a_rdata  <= a_rdata_n;
            b_rdata  <= b_rdata_n;
            ram_ad   <= ram_ad_n;
            ram_di   <= ram_di_n;
            ram_wre  <= ram_wre_n;
        end
    end

`ifdef RAM16S_ARB_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'h0;
            busy_q <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            busy_q <= busy_n;
        end
    end
`endif

endmodule

// File: tb/tb_ram16s_arbiter.sv
// Directed bench for ram16s_arbiter with a behavioural 16x8 RAM attached to the RAM port.
// Clear-sequence checks are active only when RAM16S_ARB_CLEAR_EN is defined.
module tb_ram16s_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [3:0] a_addr = 4'h0, b_addr = 4'h0;
    logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wre, busy;
    logic [7:0] a_rdata, b_rdata, ram_di, ram_dout;
    logic [3:0] ram_ad;

    logic [7:0] mem [16];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_wre) mem[ram_ad] <= ram_di;
    assign ram_dout = mem[ram_ad];

    ram16s_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_wre(ram_wre), .ram_dout(ram_dout),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 0);
        check({tag, "_rvalid"}, {30'd0, a_rvalid, b_rvalid}, 0);
        check({tag, "_rdata"}, {16'd0, a_rdata, b_rdata}, 0);
        check({tag, "_ram"}, {19'd0, ram_ad, ram_di, ram_wre}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Run the clear sequence that follows a reset release made at a falling edge.
    task automatic expect_clear(input string tag);
`ifdef RAM16S_ARB_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_ad"}, ram_ad, i);
            check({tag, "_wre"}, ram_wre, 1);
            check({tag, "_di"}, ram_di, 8'h00);
            check({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 0);
        end
        @(negedge clk);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_wre_fall"}, ram_wre, 0);
`else
        @(negedge clk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wre"}, ram_wre, 0);
`endif
    endtask

    // One request from an idle arbiter: immediate grant, then rvalid on reads.
    task automatic single(input bit use_b, input bit we, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        int k;
        if (use_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        k = 0;
        @(negedge clk);
        while (!(use_b ? b_gnt : a_gnt) && k < 20) begin
            k++;
            @(negedge clk);
        end
        check({tag, "_lat"}, k, 0);
        check({tag, "_gnt"}, use_b ? b_gnt : a_gnt, 1);
        check({tag, "_other_gnt"}, use_b ? a_gnt : b_gnt, 0);
        check({tag, "_ad"}, ram_ad, addr);
        check({tag, "_wre"}, ram_wre, we);
        if (we) check({tag, "_di"}, ram_di, wd);
        if (use_b) b_req = 1'b0; else a_req = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid"}, use_b ? b_rvalid : a_rvalid, !we);
        check({tag, "_other_rvalid"}, use_b ? a_rvalid : b_rvalid, 0);
        check({tag, "_gnt_drop"}, use_b ? b_gnt : a_gnt, 0);
        if (!we) check({tag, "_rdata"}, use_b ? b_rdata : a_rdata, exp_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_exp [3];
        int k;
        b2b_exp = '{8'h11, 8'h22, 8'h33};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        expect_clear("clear1");

        // Basic read, write then cross-requester read
        single(1'b0, 1'b0, 4'd5, 8'h00, 8'h00, "a_rd5");
        single(1'b0, 1'b1, 4'd3, 8'hA5, 8'h00, "a_wr3");
        single(1'b1, 1'b0, 4'd3, 8'h00, 8'hA5, "b_rd3");
        single(1'b1, 1'b1, 4'd9, 8'h3C, 8'h00, "b_wr9");
        single(1'b0, 1'b0, 4'd9, 8'h00, 8'h3C, "a_rd9");
        single(1'b0, 1'b1, 4'd0, 8'h11, 8'h00, "a_wr0");
        single(1'b0, 1'b1, 4'd1, 8'h22, 8'h00, "a_wr1");
        single(1'b0, 1'b1, 4'd2, 8'h33, 8'h00, "a_wr2");

        // B alone, three reads back to back, address updated at the end of each grant
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            @(negedge clk);
            while (!b_gnt && k < 20) begin
                k++;
                @(negedge clk);
            end
            check("b2b_lat", k, 0);
            check("b2b_gnt", b_gnt, 1);
            check("b2b_ad", ram_ad, i);
            check("b2b_a_gnt", a_gnt, 0);
            if (i < 2) b_addr = 4'(i + 1); else b_req = 1'b0;
            @(negedge clk);
            check("b2b_rvalid", b_rvalid, 1);
            check("b2b_gnt_drop", b_gnt, 0);
            check("b2b_rdata", b_rdata, b2b_exp[i]);
        end

        // Both requesting continuously: A (B was last) then B, alternating every 2 cycles
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("rr_a_gnt", a_gnt, (j % 4) == 0);
            check("rr_b_gnt", b_gnt, (j % 4) == 2);
            check("rr_a_rvalid", a_rvalid, (j % 4) == 1);
            check("rr_b_rvalid", b_rvalid, (j % 4) == 3);
            if ((j % 4) == 1) check("rr_a_rdata", a_rdata, 8'hA5);
            if ((j % 4) == 3) check("rr_b_rdata", b_rdata, 8'h3C);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("rr_idle_gnt", {30'd0, a_gnt, b_gnt}, 0);

        // Reset in the middle of an A read
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        k = 0;
        @(negedge clk);
        while (!a_gnt && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("rst_mid_gnt", a_gnt, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        a_req = 1'b0;
        @(negedge clk);
        check("rst_mid_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
        rst_n = 1'b1;
        expect_clear("clear2");

        // Pointer favours A again after reset even though A was granted last
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
        @(negedge clk);
        check("post_rst_a_gnt", a_gnt, 1);
        check("post_rst_b_gnt", b_gnt, 0);
        a_req = 1'b0;
        @(negedge clk);
        check("post_rst_a_rvalid", a_rvalid, 1);
`ifdef RAM16S_ARB_CLEAR_EN
        check("post_rst_a_rdata", a_rdata, 8'h00);
`else
        check("post_rst_a_rdata", a_rdata, 8'hA5);
`endif
        @(negedge clk);
        check("post_rst_b_gnt2", b_gnt, 1);
        b_req = 1'b0;
        @(negedge clk);
        check("post_rst_b_rvalid", b_rvalid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
